// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator: default widths,
// the two-state controller encoding and a small width helper.
package psum_accumulator_pkg;

    // Default widths matching the tree adder output and the accumulated result.
    localparam int PSUM_IN_W       = 20;
    localparam int PSUM_OUT_W      = 22;
    localparam int PSUM_NUM_CHUNKS = 4;

    // ACC accepts partial sums, HOLD presents a finished dot product.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } psum_state_e;

    // Bits needed to represent a beat count from 0 up to and including n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/psum_accumulator_chunk_counter.sv
// Beat counter for one dot product. Counts 0..MODULUS-1 and wraps,
// raising 'terminal' while the current value is the last beat slot.
module chunk_counter #(
    parameter int MODULUS = 4,
    parameter int W       = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         terminal
);

    logic [W-1:0] count_q;

    // The next accepted beat is the final one of a full dot product.
    assign terminal = (count_q == W'(MODULUS - 1));
    assign count    = count_q;

    // Clear wins over increment so a handshake always restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= terminal ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates signed partial sums from the tree adder into one dot product,
// closing after NUM_CHUNKS beats or on an early in_last, then holds the
// result until the consumer takes it.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int IN_W       = PSUM_IN_W,
    parameter int NUM_CHUNKS = PSUM_NUM_CHUNKS,
    parameter int OUT_W      = PSUM_OUT_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [IN_W-1:0]             in_psum,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [OUT_W-1:0]            out_sum,
    output logic [$clog2(NUM_CHUNKS+1)-1:0]    out_count
);

    localparam int CNT_W = count_width(NUM_CHUNKS);

    // Reject parameter sets where the result could overflow or the chunk
    // count is outside what the counter is built for.
    if (NUM_CHUNKS < 2 || NUM_CHUNKS > 256) begin : g_bad_chunks
        $error("psum_accumulator: NUM_CHUNKS=%0d outside 2..256", NUM_CHUNKS);
    end
    if (OUT_W < IN_W + $clog2(NUM_CHUNKS)) begin : g_bad_out_w
        $error("psum_accumulator: OUT_W=%0d too narrow for IN_W=%0d x %0d chunks",
               OUT_W, IN_W, NUM_CHUNKS);
    end

    psum_state_e             state_q;
    psum_state_e             state_d;
    logic signed [OUT_W-1:0] acc_q;
    logic signed [OUT_W-1:0] psum_ext;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        out_count_q;
    logic                    terminal;
    logic                    in_fire;
    logic                    out_fire;
    logic                    close_beat;

    // Handshakes are derived from the registered state only, so in_ready and
    // out_valid never depend combinationally on the other side's signals.
    assign in_fire    = in_valid && (state_q == ACC);
    assign out_fire   = out_ready && (state_q == HOLD);
    assign close_beat = in_fire && (terminal || in_last);
    assign psum_ext   = OUT_W'(in_psum);

    chunk_counter #(
        .MODULUS (NUM_CHUNKS),
        .W       (CNT_W)
    ) u_chunk_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (out_fire),
        .inc      (in_fire),
        .count    (count),
        .terminal (terminal)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs: accept in ACC, present in HOLD.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACC: begin
                in_ready = 1'b1;
                if (close_beat) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_fire) begin
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // Running sum and the captured beat count; both restart at the output
    // handshake. The count is latched on the closing beat because the
    // counter itself wraps to zero after a full dot product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_count_q <= '0;
        end else if (out_fire) begin
            acc_q       <= '0;
            out_count_q <= '0;
        end else if (in_fire) begin
            acc_q <= acc_q + psum_ext;
            if (close_beat) begin
                out_count_q <= count + CNT_W'(1);
            end
        end
    end

    assign out_sum   = acc_q;
    assign out_count = out_count_q;

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter IN_W, default 20, is the width of the signed partial-sum input (tree adder total_sum width).
REQ-002 Parameter NUM_CHUNKS, default 4, is the number of partial sums in one full dot product; legal range is 2..256.
REQ-003 Parameter OUT_W, default 22, is the width of the signed result; it SHALL be checked at elaboration as OUT_W >= IN_W + clog2(NUM_CHUNKS).
REQ-004 Port clk, input, 1: the single clock, rising-edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1: in_psum and in_last are valid this cycle.
REQ-007 Port in_ready, output, 1: block accepts a partial sum this cycle.
REQ-008 Port in_psum, input, IN_W: signed partial sum from the tree adder.
REQ-009 Port in_last, input, 1: this beat closes the dot product early.
REQ-010 Port out_valid, output, 1: out_sum holds a completed dot product.
REQ-011 Port out_ready, input, 1: consumer takes out_sum this cycle.
REQ-012 Port out_sum, output, OUT_W: signed accumulated dot product.
REQ-013 Port out_count, output, clog2(NUM_CHUNKS+1): number of beats summed into out_sum.

Function
REQ-014 States: ACC (accepting) and HOLD (result presented); in_ready=1 only in ACC, out_valid=1 only in HOLD.
REQ-015 Input handshake: a beat transfers when in_valid && in_ready at a clk edge; no other cycle alters the accumulator.
REQ-016 On each transfer, acc <= acc + sign-extended in_psum; count <= count + 1.
REQ-017 The transition ACC->HOLD SHALL occur on a transfer where count+1 == NUM_CHUNKS or in_last==1.
REQ-018 Latency: out_valid asserts on the edge following the closing beat; out_sum equals the full sum including that beat.
REQ-019 In HOLD, out_sum and out_count stay stable until out_valid && out_ready.
REQ-020 HOLD->ACC occurs on the output handshake; acc and count clear to 0 on that edge; in_ready rises the next cycle (one-cycle bubble, no bypass).
REQ-021 in_valid asserted while in HOLD SHALL be ignored; the producer holds its beat until in_ready.
REQ-022 Arithmetic is two's complement, with no saturation and no overflow, guaranteed by REQ-003.
REQ-023 in_last on the NUM_CHUNKS-th beat behaves identically to that beat without in_last.
REQ-024 A single beat with in_last=1 yields out_count=1 and out_sum=sign-extended in_psum.

Reset
REQ-025 rst_n low SHALL immediately force state=ACC, acc=0, count=0, out_valid=0, out_sum=0, out_count=0, independent of clk.
REQ-026 Reset asserted mid-accumulation or in HOLD discards the partial or held result; no output handshake occurs for it.
REQ-027 After rst_n deasserts, in_ready=1 at the first clk edge.

Structure
REQ-028 A shared package SHALL hold the state enum (ACC, HOLD) and the default widths PSUM_IN_W=20 and PSUM_OUT_W=22.
REQ-029 One sub-module, chunk_counter (parameterised wrap-at-N counter with terminal flag, sync clear, async reset), SHALL implement count; the accumulator register and FSM stay in the top.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Four beats of -524288 back-to-back, out_ready=1 -> out_sum=-2097152, out_count=4, out_valid one cycle after beat 4.
- Four beats of 520192 -> out_sum=2080768; no wrap.
- Beats 100, -37 with in_last on the 2nd -> out_sum=63, out_count=2; the next dot product starts from 0.
- Result held with out_ready=0 for 10 cycles while in_valid=1 with 5 -> out_sum stable, in_ready=0, beat 5 accepted only after release.
- rst_n pulsed low mid-cycle after 2 beats -> outputs zero immediately; the next 4 beats of 1 give out_sum=4.
- Random IN_W-range beats with random valid/ready stalls, 1000 dot products -> scoreboard match on out_sum and out_count.
